// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity codes, FSM state encoding and width helper for uart_core
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // One encoding serves both serial engines; each engine walks the same
   // IDLE > START > DATA > PARITY > STOP sequence.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int width_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through FIFO with registered full/empty
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push        write push_data when not full (ignored when full)
//   pop         retire the head when not empty
//   pop_data    head entry, forced to zero while empty
//   full/empty  registered status derived from the wrap-bit pointer compare
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = width_of(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_nxt;
   logic [AW:0]      rd_nxt;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the current occupancy, so a same-cycle pop never
   // makes room for a push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wr_nxt  = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
   assign rd_nxt  = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         empty  <= (wr_nxt == rd_nxt);
         full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - parametrised full-duplex UART with TX/RX FIFOs and RX error pulses
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_rx / o_tx                    serial line in (asynchronous) / out (idle high)
//   i_tx_valid/o_tx_ready/i_tx_data  TX byte handshake into the TX FIFO
//   o_tx_busy                      TX FIFO non-empty or frame on the wire
//   o_rx_valid/i_rx_ready/o_rx_data  RX FIFO head, first-word fall-through
//   o_rx_frame_err/o_rx_parity_err/o_rx_overrun  one-cycle error pulses
module uart_core
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BAUD      = 115_200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int TX_DEPTH  = 16,
   parameter int RX_DEPTH  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic                 o_tx,
   input  logic                 i_tx_valid,
   output logic                 o_tx_ready,
   input  logic [DATA_BITS-1:0] i_tx_data,
   output logic                 o_tx_busy,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_frame_err,
   output logic                 o_rx_parity_err,
   output logic                 o_rx_overrun
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = width_of(CLKS_PER_BIT);
   localparam int IDX_W        = width_of(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic             ODD_FLIP  = (PARITY == PAR_ODD);

   generate
      if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
          PARITY < PAR_NONE || PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2 ||
          TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
          RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_params
         $error("uart_core: parameter out of range");
      end
   endgenerate

   // ---------------------------------------------------------------- TX side
   logic                 tx_full, tx_empty, tx_pop, tx_tick, tx_bit;
   logic                 tx_line, tx_par;
   logic [DATA_BITS-1:0] tx_head, tx_shift;
   logic [CNT_W-1:0]     tx_cnt;
   logic [IDX_W-1:0]     tx_idx;
   uart_state_t          tx_state, tx_state_nxt;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (i_tx_valid),
      .push_data (i_tx_data),
      .pop       (tx_pop),
      .pop_data  (tx_head),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   assign tx_tick = (tx_cnt == CNT_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) tx_state <= ST_IDLE;
      else          tx_state <= tx_state_nxt;
   end

   // tx_bit is the line level for the current state; it is registered into
   // tx_line, which puts the start bit two edges after the push.
   always_comb begin
      tx_state_nxt = tx_state;
      tx_pop       = 1'b0;
      tx_bit       = 1'b1;
      case (tx_state)
         ST_IDLE: begin
            if (!tx_empty) begin
               tx_state_nxt = ST_START;
               tx_pop       = 1'b1;
            end
         end
         ST_START: begin
            tx_bit = 1'b0;
            if (tx_tick) tx_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            tx_bit = tx_shift[0];
            if (tx_tick && tx_idx == DATA_LAST)
               tx_state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
         end
         ST_PARITY: begin
            tx_bit = tx_par;
            if (tx_tick) tx_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            // Chain straight into the next start bit when more data waits.
            if (tx_tick && tx_idx == STOP_LAST) begin
               if (!tx_empty) begin
                  tx_state_nxt = ST_START;
                  tx_pop       = 1'b1;
               end else begin
                  tx_state_nxt = ST_IDLE;
               end
            end
         end
         default: tx_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tx_line  <= 1'b1;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
      end else begin
         tx_line <= tx_bit;
         if (tx_state_nxt != tx_state) begin
            tx_cnt <= '0;
            tx_idx <= '0;
         end else if (tx_tick) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + IDX_W'(1);
         end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
         end
         if (tx_pop) begin
            tx_shift <= tx_head;
            tx_par   <= (^tx_head) ^ ODD_FLIP;
         end else if (tx_state == ST_DATA && tx_tick) begin
            tx_shift <= tx_shift >> 1;
         end
      end
   end

   assign o_tx       = tx_line;
   assign o_tx_ready = !tx_full;
   assign o_tx_busy  = !tx_empty || (tx_state != ST_IDLE);

   // ---------------------------------------------------------------- RX side
   logic                 rx_meta, rx_s, rx_prev;
   logic                 rx_full, rx_empty, rx_push, rx_tick, rx_mid;
   logic                 rx_armed, rx_par, par_bad;
   logic                 ferr_d, perr_d, ovr_d;
   logic [DATA_BITS-1:0] rx_shift;
   logic [CNT_W-1:0]     rx_cnt;
   logic [IDX_W-1:0]     rx_idx;
   uart_state_t          rx_state, rx_state_nxt;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (rx_push),
      .push_data (rx_shift),
      .pop       (i_rx_ready),
      .pop_data  (o_rx_data),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign rx_tick = (rx_cnt == CNT_LAST);
   assign rx_mid  = (rx_cnt == CNT_MID);
   assign par_bad = (PARITY != PAR_NONE) && (rx_par != ((^rx_shift) ^ ODD_FLIP));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rx_state <= ST_IDLE;
      else          rx_state <= rx_state_nxt;
   end

   // STOP is left at its mid-bit sample so the next falling edge, which can
   // come at the end of this stop bit, is already watched for in IDLE.
   always_comb begin
      rx_state_nxt = rx_state;
      rx_push      = 1'b0;
      ferr_d       = 1'b0;
      perr_d       = 1'b0;
      ovr_d        = 1'b0;
      case (rx_state)
         ST_IDLE: begin
            if (rx_armed && rx_prev && !rx_s) rx_state_nxt = ST_START;
         end
         ST_START: begin
            if (rx_mid && rx_s)  rx_state_nxt = ST_IDLE;
            else if (rx_tick)    rx_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (rx_tick && rx_idx == DATA_LAST)
               rx_state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
         end
         ST_PARITY: begin
            if (rx_tick) rx_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (rx_mid) begin
               rx_state_nxt = ST_IDLE;
               ferr_d       = !rx_s;
               perr_d       = par_bad;
               if (rx_s && !par_bad) begin
                  if (rx_full) ovr_d   = 1'b1;
                  else         rx_push = 1'b1;
               end
            end
         end
         default: rx_state_nxt = ST_IDLE;
      endcase
   end

   // While disarmed, rx_cnt counts consecutive high samples in IDLE; one full
   // bit time of idle line re-arms start detection (reset and break recovery).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_cnt          <= '0;
         rx_idx          <= '0;
         rx_shift        <= '0;
         rx_par          <= 1'b0;
         rx_armed        <= 1'b0;
         o_rx_frame_err  <= 1'b0;
         o_rx_parity_err <= 1'b0;
         o_rx_overrun    <= 1'b0;
      end else begin
         o_rx_frame_err  <= ferr_d;
         o_rx_parity_err <= perr_d;
         o_rx_overrun    <= ovr_d;
         if (rx_state_nxt != rx_state) begin
            rx_cnt <= '0;
            rx_idx <= '0;
         end else if (rx_state == ST_IDLE) begin
            rx_cnt <= (rx_s && !rx_tick) ? rx_cnt + CNT_W'(1) : '0;
         end else if (rx_tick) begin
            rx_cnt <= '0;
            rx_idx <= rx_idx + IDX_W'(1);
         end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
         end
         if (rx_state == ST_IDLE && !rx_armed && rx_s && rx_tick) rx_armed <= 1'b1;
         else if (ferr_d)                                         rx_armed <= 1'b0;
         if (rx_state == ST_DATA && rx_mid)   rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
         if (rx_state == ST_PARITY && rx_mid) rx_par   <= rx_s;
      end
   end

   assign o_rx_valid = !rx_empty;

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed self-checking bench for uart_core (8N1, 7E2, 8O1 instances)
module tb_uart_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc++;

   // A: 8N1, RX_DEPTH=4, looped back
   logic       a_tx, a_tx_valid, a_tx_ready, a_tx_busy, a_rx_valid, a_rx_ready;
   logic       a_ferr, a_perr, a_ovr;
   logic [7:0] a_tx_data, a_rx_data;
   // B: 7E2, looped back
   logic       b_tx, b_tx_valid, b_tx_ready, b_tx_busy, b_rx_valid, b_rx_ready;
   logic       b_ferr, b_perr, b_ovr;
   logic [6:0] b_tx_data, b_rx_data;
   // C: 8O1, i_rx driven by the bench
   logic       c_rx, c_tx, c_tx_valid, c_tx_ready, c_tx_busy, c_rx_valid, c_rx_ready;
   logic       c_ferr, c_perr, c_ovr;
   logic [7:0] c_tx_data, c_rx_data;

   uart_core #(.CLK_HZ(800), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
               .TX_DEPTH(16), .RX_DEPTH(4)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(a_tx), .o_tx(a_tx),
      .i_tx_valid(a_tx_valid), .o_tx_ready(a_tx_ready), .i_tx_data(a_tx_data),
      .o_tx_busy(a_tx_busy), .o_rx_valid(a_rx_valid), .i_rx_ready(a_rx_ready),
      .o_rx_data(a_rx_data), .o_rx_frame_err(a_ferr), .o_rx_parity_err(a_perr),
      .o_rx_overrun(a_ovr));

   uart_core #(.CLK_HZ(800), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
               .TX_DEPTH(16), .RX_DEPTH(16)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(b_tx), .o_tx(b_tx),
      .i_tx_valid(b_tx_valid), .o_tx_ready(b_tx_ready), .i_tx_data(b_tx_data),
      .o_tx_busy(b_tx_busy), .o_rx_valid(b_rx_valid), .i_rx_ready(b_rx_ready),
      .o_rx_data(b_rx_data), .o_rx_frame_err(b_ferr), .o_rx_parity_err(b_perr),
      .o_rx_overrun(b_ovr));

   uart_core #(.CLK_HZ(800), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
               .TX_DEPTH(16), .RX_DEPTH(16)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(c_rx), .o_tx(c_tx),
      .i_tx_valid(c_tx_valid), .o_tx_ready(c_tx_ready), .i_tx_data(c_tx_data),
      .o_tx_busy(c_tx_busy), .o_rx_valid(c_rx_valid), .i_rx_ready(c_rx_ready),
      .o_rx_data(c_rx_data), .o_rx_frame_err(c_ferr), .o_rx_parity_err(c_perr),
      .o_rx_overrun(c_ovr));

   int a_ferr_n = 0, a_perr_n = 0, a_ovr_n = 0, b_err_n = 0;
   int c_ferr_n = 0, c_perr_n = 0, c_ovr_n = 0;
   always @(negedge clk) begin
      if (a_ferr) a_ferr_n++;
      if (a_perr) a_perr_n++;
      if (a_ovr)  a_ovr_n++;
      if (b_ferr || b_perr || b_ovr) b_err_n++;
      if (c_ferr) c_ferr_n++;
      if (c_perr) c_perr_n++;
      if (c_ovr)  c_ovr_n++;
   end

   logic mon_sel;
   logic tx_mon;
   assign tx_mon = mon_sel ? b_tx : a_tx;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Called at the negedge just after the monitored line fell; samples mid-bit.
   task automatic capture(input int nbits, output logic [31:0] bits);
      bits = '0;
      repeat (4) @(negedge clk);
      bits[0] = tx_mon;
      for (int i = 1; i < nbits; i++) begin
         repeat (8) @(negedge clk);
         bits[i] = tx_mon;
      end
   endtask

   task automatic wait_low(input string tag, input int budget);
      int k;
      for (k = 0; k < budget && tx_mon !== 1'b0; k++) @(negedge clk);
      check(tag, tx_mon, 1'b0);
   endtask

   // Odd-parity frame for C: start, 8 data LSB first, parity, stop; line left at stop.
   task automatic send_c(input logic [7:0] d, input logic flip_par, input logic stop);
      logic [10:0] fr;
      fr = {stop, (~^d) ^ flip_par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         c_rx = fr[i];
         repeat (8) @(negedge clk);
      end
   endtask

   logic [31:0] cap;
   logic [7:0]  bytes5 [5];
   int          t0;

   initial begin
      rst_n = 1'b0;
      a_tx_valid = 0; a_tx_data = 0; a_rx_ready = 0;
      b_tx_valid = 0; b_tx_data = 0; b_rx_ready = 0;
      c_tx_valid = 0; c_tx_data = 0; c_rx_ready = 0; c_rx = 1'b1;
      mon_sel = 1'b0;
      bytes5[0] = 8'h01; bytes5[1] = 8'h80; bytes5[2] = 8'hFF;
      bytes5[3] = 8'h3C; bytes5[4] = 8'hC3;
      repeat (3) @(negedge clk);
      check("rst_tx",       a_tx,       1'b1);
      check("rst_tx_ready", a_tx_ready, 1'b1);
      check("rst_tx_busy",  a_tx_busy,  1'b0);
      check("rst_rx_valid", a_rx_valid, 1'b0);
      check("rst_rx_data",  a_rx_data,  8'h00);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // 8N1 single byte: start bit two edges after the push, 80 cycles to RX.
      a_tx_data = 8'hA5; a_tx_valid = 1'b1;
      @(negedge clk);
      a_tx_valid = 1'b0;
      check("t1_busy", a_tx_busy, 1'b1);
      @(negedge clk);
      check("t1_tx_n1", a_tx, 1'b1);
      @(negedge clk);
      check("t1_tx_n2", a_tx, 1'b0);
      t0 = cyc;
      capture(10, cap);
      check("t1_frame", cap, {22'b0, 1'b1, 8'hA5, 1'b0});
      for (int k = 0; k < 20 && !a_rx_valid; k++) @(negedge clk);
      check("t1_rx_valid",   a_rx_valid, 1'b1);
      check("t1_rx_latency", cyc - t0, 80);
      check("t1_rx_data",    a_rx_data, 8'hA5);
      check("t1_no_err",     a_ferr_n + a_perr_n + a_ovr_n, 0);
      a_rx_ready = 1'b1; @(negedge clk); a_rx_ready = 1'b0;
      check("t1_popped", a_rx_valid, 1'b0);

      // 7E2 back-to-back: contiguous frames, parity 0 then 1.
      mon_sel = 1'b1;
      b_tx_data = 7'h55; b_tx_valid = 1'b1;
      @(negedge clk);
      b_tx_data = 7'h2A;
      @(negedge clk);
      b_tx_valid = 1'b0;
      wait_low("t2_start", 10);
      capture(22, cap);
      check("t2_frames", cap, {10'b0, 2'b11, 1'b1, 7'h2A, 1'b0, 2'b11, 1'b0, 7'h55, 1'b0});
      check("t2_par0", cap[8],  1'b0);
      check("t2_par1", cap[19], 1'b1);
      for (int k = 0; k < 40 && !b_rx_valid; k++) @(negedge clk);
      check("t2_rx0", b_rx_data, 7'h55);
      b_rx_ready = 1'b1; @(negedge clk); b_rx_ready = 1'b0;
      for (int k = 0; k < 100 && !b_rx_valid; k++) @(negedge clk);
      check("t2_rx1", b_rx_data, 7'h2A);
      b_rx_ready = 1'b1; @(negedge clk); b_rx_ready = 1'b0;
      check("t2_rx_empty", b_rx_valid, 1'b0);
      check("t2_no_err",   b_err_n, 0);

      // Overrun: RX_DEPTH=4, five bytes with no pops.
      mon_sel = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_tx_data = bytes5[i]; a_tx_valid = 1'b1;
         @(negedge clk);
      end
      a_tx_valid = 1'b0;
      for (int k = 0; k < 800 && a_tx_busy; k++) @(negedge clk);
      check("t3_tx_done", a_tx_busy, 1'b0);
      repeat (20) @(negedge clk);
      check("t3_ovr_once", a_ovr_n, 1);
      check("t3_no_ferr",  a_ferr_n + a_perr_n, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_valid%0d", i), a_rx_valid, 1'b1);
         check($sformatf("t3_data%0d", i),  a_rx_data, bytes5[i]);
         a_rx_ready = 1'b1; @(negedge clk); a_rx_ready = 1'b0;
      end
      check("t3_empty", a_rx_valid, 1'b0);

      // 8O1 driven line: good byte, parity error, frame error with break.
      send_c(8'h96, 1'b0, 1'b1);
      for (int k = 0; k < 20 && !c_rx_valid; k++) @(negedge clk);
      check("t4_good",     c_rx_data, 8'h96);
      check("t4_good_err", c_ferr_n + c_perr_n + c_ovr_n, 0);
      c_rx_ready = 1'b1; @(negedge clk); c_rx_ready = 1'b0;
      send_c(8'h3C, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      check("t4_perr",       c_perr_n, 1);
      check("t4_perr_noferr", c_ferr_n, 0);
      check("t4_perr_nowr",  c_rx_valid, 1'b0);
      send_c(8'hA5, 1'b0, 1'b0);
      repeat (16) @(negedge clk);
      check("t4_ferr",      c_ferr_n, 1);
      check("t4_ferr_nope", c_perr_n, 1);
      check("t4_ferr_nowr", c_rx_valid, 1'b0);
      c_rx = 1'b1;
      repeat (4) @(negedge clk);
      send_c(8'h00, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      check("t4_not_rearmed", c_rx_valid, 1'b0);
      send_c(8'h5A, 1'b0, 1'b1);
      for (int k = 0; k < 20 && !c_rx_valid; k++) @(negedge clk);
      check("t4_rearmed", c_rx_data, 8'h5A);
      c_rx_ready = 1'b1; @(negedge clk); c_rx_ready = 1'b0;

      // 3-cycle glitch is rejected silently.
      c_rx = 1'b0;
      repeat (3) @(negedge clk);
      c_rx = 1'b1;
      repeat (40) @(negedge clk);
      check("t5_glitch_valid", c_rx_valid, 1'b0);
      check("t5_glitch_err",   c_ferr_n * 100 + c_perr_n * 10 + c_ovr_n, 110);

      // Reset in the middle of a frame, with a byte waiting in the RX FIFO.
      a_tx_data = 8'hC3; a_tx_valid = 1'b1;
      @(negedge clk);
      a_tx_data = 8'h3C;
      @(negedge clk);
      a_tx_valid = 1'b0;
      for (int k = 0; k < 120 && !a_rx_valid; k++) @(negedge clk);
      check("t6_first_rx", a_rx_data, 8'hC3);
      repeat (40) @(negedge clk);
      check("t6_busy_pre", a_tx_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_tx",       a_tx,       1'b1);
      check("t6_busy",     a_tx_busy,  1'b0);
      check("t6_ready",    a_tx_ready, 1'b1);
      check("t6_rx_valid", a_rx_valid, 1'b0);
      check("t6_rx_data",  a_rx_data,  8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
